// File: rtl/mc_mem_responder.sv
// Single-port word memory responder for the multi-cycle core: one request in
// flight, fixed wait states, one registered response strobe per accepted request.
module mc_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic              err;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q, req_d;
  req_t               in_req, op;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               enter_resp;
  logic               mem_we;

  logic [DATA_W-1:0]  mem [2**ADDR_W];

  // Any set bit above the word index is an error, never an alias.
  always_comb begin
    in_req       = '0;
    in_req.we    = req_we;
    in_req.err   = (req_addr[1:0] != 2'b00) | ((req_addr >> (ADDR_W + 2)) != 32'd0);
    in_req.idx   = req_addr[ADDR_W+1:2];
    in_req.wdata = req_wdata;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    op         = req_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          cnt_d = CNT_LOAD;
          // With no wait states the response is formed straight from the inputs.
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
            op         = in_req;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) enter_resp = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d = RESP;
      err_d   = op.err;
      rdata_d = (op.err || op.we) ? '0 : mem[op.idx];
    end
  end

  // Commit happens only on the RESP-entry edge, so a reset in WAIT drops it.
  assign mem_we = enter_resp & op.we & ~op.err & ~reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[op.idx] <= op.wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: three instances (2, 3, 0 wait states) driven from a
// vector table plus hand sequences; responses checked against a scoreboard queue.
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  always #5 clk = ~clk;

  mc_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  mc_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  mc_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  typedef struct {
    int          sel;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          sel;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  exp_t        q[$];
  exp_t        mon_e;
  vec_t        tbl[14];
  logic [31:0] pre[4];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int s);
    case (s)
      0:       return 2;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (resp_valid[s] === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: inst %0d got resp_valid=1 expected none", s);
        end else begin
          mon_e = q.pop_front();
          check("resp_inst", s, mon_e.sel);
          check("resp_rdata", resp_rdata[s], mon_e.rdata);
          check("resp_err", {31'd0, resp_err[s]}, {31'd0, mon_e.err});
          check("resp_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(int sel, bit we, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] exp_rd, bit exp_err, bit push);
    int n = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 3'b000;
    req_valid[sel] = 1'b1;
    @(negedge clk);
    while (req_ready[sel] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: inst %0d req_ready=%b expected 1", sel, req_ready[sel]);
    end
    if (push) q.push_back('{sel, exp_rd, exp_err, cyc + wc(sel) + 1});
    @(posedge clk);
    #1;
    // Scramble the request lines after acceptance; the DUT must use its latched copy.
    req_valid = 3'b000;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: outstanding=%0d expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    for (int s = 0; s < 3; s++) begin
      check("rst_ready", {31'd0, req_ready[s]}, 32'd1);
      check("rst_valid", {31'd0, resp_valid[s]}, 32'd0);
      check("rst_rdata", resp_rdata[s], 32'd0);
      check("rst_err", {31'd0, resp_err[s]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pre[0] = 32'hA000_0000;
    pre[1] = 32'hA111_1111;
    pre[2] = 32'hA222_2222;
    pre[3] = 32'hA333_3333;

    tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{0, 1'b1, 32'h0000_0012, 32'h1,         32'h0,         1'b1};
    tbl[3]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{0, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1};
    tbl[5]  = '{0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0,         1'b0};
    tbl[6]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         32'h1234_5678, 1'b0};
    tbl[7]  = '{0, 1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{0, 1'b0, 32'h0000_0003, 32'h0,         32'h0,         1'b1};
    tbl[9]  = '{1, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0,         1'b0};
    tbl[10] = '{2, 1'b1, 32'h0000_0000, pre[0],        32'h0,         1'b0};
    tbl[11] = '{2, 1'b1, 32'h0000_0004, pre[1],        32'h0,         1'b0};
    tbl[12] = '{2, 1'b1, 32'h0000_0008, pre[2],        32'h0,         1'b0};
    tbl[13] = '{2, 1'b1, 32'h0000_000C, pre[3],        32'h0,         1'b0};

    req_valid = 3'b000;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_rd, tbl[i].exp_err, 1'b1);
      wait_idle();
    end

    // Reset in the second wait cycle of a 3-wait write: no response, no commit.
    issue(1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_resp", {31'd0, resp_valid[1]}, 32'd0);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0, 1'b1);
    wait_idle();

    // Zero-wait back-to-back reads with req_valid held high.
    begin
      int  n = 0;
      bit  acc;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_valid = 3'b100;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("tput_ready", {31'd0, req_ready[2]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        acc = (req_ready[2] === 1'b1);
        if (acc && n < 4) q.push_back('{2, pre[n], 1'b0, cyc + 1});
        @(posedge clk);
        #1;
        if (acc) begin
          n++;
          req_addr = 32'(n * 4);
        end
      end
      req_valid = 3'b000;
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
